// File: rtl/bf_core_param.sv
// bf_core_param: brainfuck core on external program ROM and tape RAM; define BF_INSTR_COUNT_EN to add instr_count
module bf_core_param #(
  parameter int DATA_W = 8,
  parameter int SP_W = 16,
  parameter int PC_W = 16,
  parameter int PROG_LEN = 1024
) (
  input  logic              clock,
  input  logic              reset,
  output logic [PC_W-1:0]   pc,
  input  logic [2:0]        pmem_data_read,
  output logic [SP_W-1:0]   sp,
  input  logic [DATA_W-1:0] tape_data_read,
  output logic              tape_we,
  output logic [DATA_W-1:0] tape_data_write,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              halted,
  output logic              error
`ifdef BF_INSTR_COUNT_EN
  ,
  output logic [31:0]       instr_count
`endif
);
  typedef enum logic [2:0] {FETCH, EXEC, SKIP_FWD, SKIP_BWD, IN_WAIT, OUT_WAIT, HALT} state_t;
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_END = PC_W'(PROG_LEN);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);
  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
  localparam logic [DATA_W-1:0] D_ONE = DATA_W'(1);
  state_t state, state_n;
  logic [2:0] op, op_n;
  logic [PC_W-1:0] pc_n, depth, depth_n;
  logic [SP_W-1:0] sp_n;
  logic [DATA_W-1:0] out_data_n;
  logic error_n;
  logic cell_zero;
  assign cell_zero = tape_data_read == '0;
  assign halted = state == HALT;
  assign in_ready = state == IN_WAIT;
  assign out_valid = state == OUT_WAIT;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc <= '0;
      sp <= '0;
      op <= '0;
      depth <= '0;
      out_data <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      sp <= sp_n;
      op <= op_n;
      depth <= depth_n;
      out_data <= out_data_n;
      error <= error_n;
    end
  end
`ifdef BF_INSTR_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) instr_count <= '0;
    else if (state != FETCH && state_n == FETCH) instr_count <= instr_count + 32'd1;
  end
`endif
  always_comb begin
    state_n = state;
    pc_n = pc;
    sp_n = sp;
    op_n = op;
    depth_n = depth;
    out_data_n = out_data;
    error_n = error;
    tape_we = 1'b0;
    tape_data_write = '0;
    case (state)
      FETCH: begin
        state_n = pc == PC_END ? HALT : EXEC;
        op_n = pc == PC_END ? op : pmem_data_read;
      end
      EXEC: begin
        pc_n = pc + PC_ONE;
        state_n = FETCH;
        case (op)
          3'd0, 3'd1: begin
            tape_we = ~reset;
            tape_data_write = op[0] ? tape_data_read - D_ONE : tape_data_read + D_ONE;
          end
          3'd2: sp_n = sp + SP_ONE;
          3'd3: sp_n = sp - SP_ONE;
          3'd4: begin
            depth_n = cell_zero ? PC_ONE : depth;
            state_n = cell_zero ? SKIP_FWD : FETCH;
          end
          3'd5: begin
            depth_n = cell_zero ? depth : PC_ONE;
            pc_n = cell_zero ? pc + PC_ONE : pc - PC_ONE;
            state_n = cell_zero ? FETCH : SKIP_BWD;
          end
          3'd6: begin
            pc_n = pc;
            state_n = IN_WAIT;
          end
          default: begin
            pc_n = pc;
            out_data_n = tape_data_read;
            state_n = OUT_WAIT;
          end
        endcase
      end
      SKIP_FWD: begin
        if (pmem_data_read == 3'd5 && depth == PC_ONE && pc < PC_END) begin
          pc_n = pc + PC_ONE;
          state_n = FETCH;
        end else if (pc >= PC_LAST) begin
          error_n = 1'b1;
          state_n = HALT;
        end else begin
          pc_n = pc + PC_ONE;
          depth_n = pmem_data_read == 3'd4 ? depth + PC_ONE : pmem_data_read == 3'd5 ? depth - PC_ONE : depth;
        end
      end
      SKIP_BWD: begin
        if (pmem_data_read == 3'd4 && depth == PC_ONE) begin
          pc_n = pc + PC_ONE;
          state_n = FETCH;
        end else if (pc == '0) begin
          error_n = 1'b1;
          state_n = HALT;
        end else begin
          pc_n = pc - PC_ONE;
          depth_n = pmem_data_read == 3'd5 ? depth + PC_ONE : pmem_data_read == 3'd4 ? depth - PC_ONE : depth;
        end
      end
      IN_WAIT: begin
        tape_we = in_valid & ~reset;
        tape_data_write = in_valid ? in_data : '0;
        pc_n = in_valid ? pc + PC_ONE : pc;
        state_n = in_valid ? FETCH : IN_WAIT;
      end
      OUT_WAIT: begin
        pc_n = out_ready ? pc + PC_ONE : pc;
        state_n = out_ready ? FETCH : OUT_WAIT;
      end
      HALT: state_n = HALT;
      default: state_n = FETCH;
    endcase
  end
endmodule

// File: tb/tb_bf_core_param.sv
// tb_bf_core_param: scoreboarded directed programs across per-program bf_core_param instances
module tb_bf_core_param;
  localparam int N = 6;
  localparam int PL [N] = '{3, 2, 7, 5, 2, 1};
  typedef struct {
    int inst;
    int kind;
    logic [15:0] addr;
    logic [7:0] data;
  } ev_t;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst [N];
  logic [15:0] pc_a [N];
  logic [15:0] sp_a [N];
  logic [2:0] pm_a [N];
  logic [7:0] rd_a [N];
  logic [7:0] wd_a [N];
  logic [7:0] ind_a [N];
  logic [7:0] outd_a [N];
  logic we_a [N];
  logic inv_a [N];
  logic inr_a [N];
  logic outv_a [N];
  logic outr_a [N];
  logic hal_a [N];
  logic err_a [N];
  logic [7:0] tape [N][4];
  int ov_n [N] = '{default: 0};
  int pc3_n [N] = '{default: 0};
  logic ov_prev [N] = '{default: 1'b0};
  logic [7:0] od_prev [N] = '{default: 8'h0};
  logic [15:0] pc_prev [N] = '{default: 16'h0};
  ev_t sbq [$];
  int n_chk = 0;
  int n_pass = 0;

  for (genvar g = 0; g < N; g++) begin : u
    bf_core_param #(.DATA_W(8), .SP_W(16), .PC_W(16), .PROG_LEN(PL[g])) dut (
      .clock(clock),
      .reset(rst[g]),
      .pc(pc_a[g]),
      .pmem_data_read(pm_a[g]),
      .sp(sp_a[g]),
      .tape_data_read(rd_a[g]),
      .tape_we(we_a[g]),
      .tape_data_write(wd_a[g]),
      .in_valid(inv_a[g]),
      .in_data(ind_a[g]),
      .in_ready(inr_a[g]),
      .out_valid(outv_a[g]),
      .out_data(outd_a[g]),
      .out_ready(outr_a[g]),
      .halted(hal_a[g]),
      .error(err_a[g])
    );
  end

  function automatic logic [2:0] opc(int i, int p);
    string s;
    byte c;
    case (i)
      0: s = "+++";
      1: s = "-<";
      2: s = "[+[-]].";
      3: s = "++[-]";
      4: s = ",.";
      default: s = "[";
    endcase
    c = (p < s.len()) ? s.getc(p) : 8'h2B;
    case (c)
      8'h2B: return 3'd0;
      8'h2D: return 3'd1;
      8'h3E: return 3'd2;
      8'h3C: return 3'd3;
      8'h5B: return 3'd4;
      8'h5D: return 3'd5;
      8'h2C: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pm_a[i] = opc(i, int'(pc_a[i]));
      rd_a[i] = tape[i][sp_a[i][1:0]];
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (rst[i]) tape[i] <= '{default: 8'h0};
      else if (we_a[i]) tape[i][sp_a[i][1:0]] <= wd_a[i];
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic expect_ev(int i, int k, logic [15:0] a, logic [7:0] d);
    ev_t e;
    e.inst = i;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(int i, int k, logic [15:0] a, logic [7:0] d);
    ev_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      $display("FAIL sb_unexpected: inst %0d kind %0d data %0h, want no event", i, k, d);
    end else begin
      e = sbq.pop_front();
      chk("sb_inst", i, e.inst);
      chk("sb_kind", k, e.kind);
      chk("sb_addr", a, e.addr);
      chk("sb_data", d, e.data);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (we_a[i]) sb_pop(i, 0, sp_a[i], wd_a[i]);
      if (outv_a[i] && outr_a[i]) sb_pop(i, 1, 16'h0, outd_a[i]);
      if (outv_a[i]) begin
        ov_n[i]++;
        if (ov_prev[i]) chk("out_stable", outd_a[i], od_prev[i]);
      end
      if (pc_a[i] == 16'd3 && pc_prev[i] != 16'd3) pc3_n[i]++;
      ov_prev[i] <= outv_a[i];
      od_prev[i] <= outd_a[i];
      pc_prev[i] <= pc_a[i];
    end
  end

  task automatic release_rst(int i);
    @(posedge clock);
    #2 rst[i] = 1'b0;
  endtask

  task automatic wait_halt(int i, int budget);
    int c = 0;
    while (hal_a[i] !== 1'b1 && c < budget) begin
      @(posedge clock);
      #1 c++;
    end
    chk("halt_reached", hal_a[i], 1);
  endtask

  initial begin
    logic [15:0] p;
    int c;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      inv_a[i] = 1'b0;
      ind_a[i] = 8'h0;
      outr_a[i] = 1'b1;
    end
    outr_a[4] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_pc", pc_a[0], 0);
    chk("rst_sp", sp_a[0], 0);
    chk("rst_we", we_a[0], 0);
    chk("rst_wd", wd_a[0], 0);
    chk("rst_in_ready", inr_a[0], 0);
    chk("rst_out_valid", outv_a[0], 0);
    chk("rst_out_data", outd_a[0], 0);
    chk("rst_halted", hal_a[0], 0);
    chk("rst_error", err_a[0], 0);

    expect_ev(0, 0, 16'h0, 8'h01);
    expect_ev(0, 0, 16'h0, 8'h02);
    expect_ev(0, 0, 16'h0, 8'h03);
    release_rst(0);
    repeat (6) @(posedge clock);
    #1 chk("t0_halted_at6", hal_a[0], 0);
    @(posedge clock);
    #1 chk("t0_halted_at7", hal_a[0], 1);
    chk("t0_error", err_a[0], 0);
    chk("t0_cell", tape[0][0], 8'h03);

    expect_ev(1, 0, 16'h0, 8'hFF);
    release_rst(1);
    wait_halt(1, 50);
    chk("t1_sp", sp_a[1], 16'hFFFF);
    chk("t1_cell", tape[1][0], 8'hFF);
    chk("t1_error", err_a[1], 0);

    expect_ev(2, 1, 16'h0, 8'h00);
    release_rst(2);
    wait_halt(2, 100);
    chk("t2_error", err_a[2], 0);
    chk("t2_pc_end", pc_a[2], 7);

    expect_ev(3, 0, 16'h0, 8'h01);
    expect_ev(3, 0, 16'h0, 8'h02);
    expect_ev(3, 0, 16'h0, 8'h01);
    expect_ev(3, 0, 16'h0, 8'h00);
    release_rst(3);
    wait_halt(3, 100);
    chk("t3_cell", tape[3][0], 8'h00);
    chk("t3_pc3_entries", pc3_n[3], 3);
    chk("t3_error", err_a[3], 0);

    expect_ev(4, 0, 16'h0, 8'h41);
    expect_ev(4, 1, 16'h0, 8'h41);
    release_rst(4);
    repeat (5) @(posedge clock);
    #2 ind_a[4] = 8'h41;
    inv_a[4] = 1'b1;
    @(posedge clock);
    #2 inv_a[4] = 1'b0;
    chk("t4_in_ready_clr", inr_a[4], 0);
    c = 0;
    while (outv_a[4] !== 1'b1 && c < 20) begin
      @(posedge clock);
      #1 c++;
    end
    chk("t4_out_valid", outv_a[4], 1);
    chk("t4_out_data", outd_a[4], 8'h41);
    repeat (3) @(posedge clock);
    #2 outr_a[4] = 1'b1;
    wait_halt(4, 20);
    outr_a[4] = 1'b0;
    chk("t4_out_cycles", ov_n[4], 4);
    chk("t4_cell", tape[4][0], 8'h41);

    release_rst(5);
    wait_halt(5, 20);
    chk("t5_error", err_a[5], 1);
    p = pc_a[5];
    repeat (3) @(posedge clock);
    #1 chk("t5_pc_frozen", pc_a[5], p);
    chk("t5_still_halted", hal_a[5], 1);
    @(posedge clock);
    #2 rst[5] = 1'b1;
    release_rst(5);
    repeat (2) @(posedge clock);
    #1 chk("t5_in_skip_pc", pc_a[5], 1);
    chk("t5_in_skip_halted", hal_a[5], 0);
    #1 rst[5] = 1'b1;
    @(posedge clock);
    #1;
    chk("t5_rst_pc", pc_a[5], 0);
    chk("t5_rst_sp", sp_a[5], 0);
    chk("t5_rst_we", we_a[5], 0);
    chk("t5_rst_wd", wd_a[5], 0);
    chk("t5_rst_in_ready", inr_a[5], 0);
    chk("t5_rst_out_valid", outv_a[5], 0);
    chk("t5_rst_out_data", outd_a[5], 0);
    chk("t5_rst_halted", hal_a[5], 0);
    chk("t5_rst_error", err_a[5], 0);

    repeat (2) @(posedge clock);
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end
endmodule

// File: doc/bf_core_param.md
BF_CORE_PARAM -- requirements
Module: bf_core_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning tape cell width in bits.
REQ-002 SHALL have parameter SP_W, default 16, meaning tape address width.
REQ-003 SHALL have parameter PC_W, default 16, meaning program address width.
REQ-004 SHALL have parameter PROG_LEN, default 1024, meaning instruction count; valid pc range 0..PROG_LEN-1.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port pc, output, PC_W, program ROM address.
REQ-008 SHALL have port pmem_data_read, input, 3, opcode at pc, valid combinationally in the same cycle.
REQ-009 SHALL have port sp, output, SP_W, tape address.
REQ-010 SHALL have port tape_data_read, input, DATA_W, cell at sp, valid combinationally in the same cycle.
REQ-011 SHALL have ports tape_we, output, 1, and tape_data_write, output, DATA_W; the cell is written at the clock edge where tape_we=1.
REQ-012 SHALL have ports in_valid, input, 1; in_data, input, DATA_W; in_ready, output, 1; these form the input stream.
REQ-013 SHALL have ports out_valid, output, 1; out_data, output, DATA_W; out_ready, input, 1; these form the output stream.
REQ-014 SHALL have ports halted, output, 1, and error, output, 1.

Function
REQ-015 Opcodes SHALL be 0 inc, 1 dec, 2 incsp, 3 decsp, 4 lloop '[', 5 rloop ']', 6 cin, 7 cout.
REQ-016 States SHALL be FETCH, EXEC, SKIP_FWD, SKIP_BWD, IN_WAIT, OUT_WAIT, HALT.
REQ-017 FETCH SHALL go to HALT with halted=1 if pc==PROG_LEN; otherwise it SHALL latch the opcode and go to EXEC.
REQ-018 EXEC for inc/dec SHALL drive tape_we=1 for exactly one cycle with the cell +/-1 mod 2^DATA_W, then pc+1 and FETCH; this takes 2 cycles per instruction.
REQ-019 EXEC for incsp/decsp SHALL set sp +/-1 mod 2^SP_W (0 minus 1 gives all ones), then pc+1 and FETCH.
REQ-020 lloop with cell==0 SHALL set depth=1 and pc+1, then enter SKIP_FWD; lloop with cell!=0 SHALL do pc+1 and go to FETCH.
REQ-021 Each cycle in SKIP_FWD SHALL do the following: '[' gives depth+1; ']' with depth==1 gives pc+1 and FETCH; ']' otherwise gives depth-1; every non-terminal cycle gives pc+1.
REQ-022 rloop with cell!=0 SHALL set depth=1 and pc-1, then enter SKIP_BWD; rloop with cell==0 SHALL do pc+1 and go to FETCH.
REQ-023 Each cycle in SKIP_BWD SHALL do the following: ']' gives depth+1; '[' with depth==1 gives pc+1 and FETCH; '[' otherwise gives depth-1; every non-terminal cycle gives pc-1.
REQ-024 The depth counter SHALL be PC_W bits wide.
REQ-025 An unmatched bracket SHALL set error=1 and halted=1 and enter HALT, with pc frozen; this applies to SKIP_FWD at pc==PROG_LEN-1 and SKIP_BWD at pc==0, when not terminating.
REQ-026 cin SHALL enter IN_WAIT with in_ready=1; when in_valid=1, in_data SHALL be written with tape_we=1, in_ready cleared, pc+1, and FETCH.
REQ-027 cout SHALL register out_data=cell and out_valid=1 in OUT_WAIT; these SHALL stay stable until the cycle with out_ready=1, then out_valid=0, pc+1, FETCH.
REQ-028 tape_we SHALL never be 1 outside EXEC(inc/dec) or the accepting IN_WAIT cycle.
REQ-029 HALT SHALL be absorbing until reset: no writes, handshakes deasserted.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set pc=0, sp=0, tape_we=0, tape_data_write=0, in_ready=0, out_valid=0, out_data=0, halted=0, error=0, depth=0, state FETCH.
REQ-031 Reset SHALL take priority in any state, including SKIP or a wait state with a pending handshake; no write SHALL occur in the reset cycle.

Configuration
REQ-032 With BF_INSTR_COUNT_EN defined, the block SHALL add output instr_count, 32 bits, reset 0; it SHALL increment once per retired instruction (each pc advance out of EXEC, IN_WAIT, OUT_WAIT, or skip termination) and wrap at 2^32.
REQ-033 Without BF_INSTR_COUNT_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-034 Program "+++" with PROG_LEN=3 and cell 0 SHALL give cell=3 and halted=1 after 7 cycles post-reset, with error=0.
REQ-035 Program "-<" with sp=0 and cell 0 SHALL give a cell of 0xFF written at sp 0, then sp=0xFFFF.
REQ-036 Program "[+[-]]." with cell 0 SHALL skip to pc 6 without any tape_we, then give out_valid with out_data=0.
REQ-037 Program "++[-]" SHALL leave cell 0 and halt; pc SHALL revisit 3 twice.
REQ-038 Program ",." with in_valid held low 5 cycles, then in_data=0x41, and out_ready low 3 cycles SHALL give out_data=0x41 held stable for 4 out_valid cycles.
REQ-039 Program "[" with cell 0 SHALL give error=1 and halted=1; then reset=1 mid-SKIP on a rerun SHALL clear all outputs to their reset values.
